// File: rtl/bz_music_seq_if.sv
// Signal bundle between a music sequencer, its note ROM and the tone PWM.
// The sequencer is the slave; the controller/ROM/PWM side is the master.
interface bz_music_seq_if #(
   parameter int SONG_W = 2,
   parameter int SEG_W  = 6,
   parameter int NOTE_W = 5,
   parameter int BEAT_W = 4
);
   // No valid/ready pair: rom_addr is registered and the ROM must return
   // rom_data exactly one clock later, holding it while rom_addr is stable.
   logic                     en;
   logic                     pause;
   logic                     loop;
   logic [SONG_W-1:0]        song_sel;
   logic [SONG_W+SEG_W-1:0]  rom_addr;
   logic [NOTE_W+BEAT_W-1:0] rom_data;
   logic [NOTE_W-1:0]        note_code;
   logic                     tone_en;
   logic                     tone_rstn;
   logic                     busy;
   logic                     done;
   logic [2:0]               state;

   modport master (
      output en, pause, loop, song_sel, rom_data,
      input  rom_addr, note_code, tone_en, tone_rstn, busy, done, state
   );

   modport slave (
      input  en, pause, loop, song_sel, rom_data,
      output rom_addr, note_code, tone_en, tone_rstn, busy, done, state
   );
endinterface

// File: rtl/bz_music_seq.sv
// Note-ROM music sequencer: walks {note, beat} entries of one song and drives
// a tone PWM, with pause/hold, looping and level-sensitive abort.
module bz_music_seq #(
   parameter int SONG_W   = 2,
   parameter int SEG_W    = 6,
   parameter int NOTE_W   = 5,
   parameter int BEAT_W   = 4,
   parameter int TICK_DIV = 3_125_000,
   parameter int GAP_CYC  = 250_000
) (
   input logic           clk,
   input logic           rstn,
   bz_music_seq_if.slave bus
);

   localparam int TICK_CW = $clog2(TICK_DIV);
   localparam int GAP_CW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [TICK_CW-1:0] TICK_LAST = TICK_CW'(TICK_DIV - 1);
   localparam logic [GAP_CW-1:0]  GAP_LAST  = GAP_CW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_LOAD  = 3'd3,
      S_PLAY  = 3'd4,
      S_GAP   = 3'd5,
      S_HOLD  = 3'd6
   } state_t;

   state_t                    state, nxt;
   state_t                    ret, ret_n;
   logic [SONG_W-1:0]         song, song_n;
   logic [SEG_W-1:0]          offset, offset_n;
   logic [NOTE_W-1:0]         note, note_n;
   logic [BEAT_W-1:0]         beat_cnt, beat_n;
   logic [TICK_CW-1:0]        tick, tick_n;
   logic [GAP_CW-1:0]         gap, gap_n;
   logic [SONG_W+SEG_W-1:0]   addr, addr_n;
   logic                      tone_en_q, tone_en_n;
   logic                      tone_rstn_q, tone_rstn_n;
   logic                      busy_q, done_q, done_n;
   logic                      eos;
   logic [NOTE_W-1:0]         rom_note;
   logic [BEAT_W-1:0]         rom_beat;

   assign rom_note = bus.rom_data[NOTE_W+BEAT_W-1:BEAT_W];
   assign rom_beat = bus.rom_data[BEAT_W-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         ret         <= S_IDLE;
         song        <= '0;
         offset      <= '0;
         note        <= '0;
         beat_cnt    <= '0;
         tick        <= '0;
         gap         <= '0;
         addr        <= '0;
         tone_en_q   <= 1'b0;
         tone_rstn_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= nxt;
         ret         <= ret_n;
         song        <= song_n;
         offset      <= offset_n;
         note        <= note_n;
         beat_cnt    <= beat_n;
         tick        <= tick_n;
         gap         <= gap_n;
         addr        <= addr_n;
         tone_en_q   <= tone_en_n;
         tone_rstn_q <= tone_rstn_n;
         busy_q      <= (nxt != S_IDLE);
         done_q      <= done_n;
      end
   end

   // Outputs are registered from the next-state decision, so each output
   // reflects the state entered on the same edge.
   always_comb begin
      nxt      = state;
      ret_n    = ret;
      song_n   = song;
      offset_n = offset;
      note_n   = note;
      beat_n   = beat_cnt;
      tick_n   = tick;
      gap_n    = gap;
      done_n   = 1'b0;
      eos      = 1'b0;

      case (state)
         S_IDLE: begin
            if (bus.en) begin
               nxt      = S_FETCH;
               song_n   = bus.song_sel;
               offset_n = '0;
            end
         end
         S_FETCH: nxt = S_WAIT;
         S_WAIT:  nxt = S_LOAD;
         S_LOAD: begin
            if (rom_beat == '0) begin
               eos = 1'b1;
            end else begin
               note_n = rom_note;
               beat_n = rom_beat;
               tick_n = '0;
               ret_n  = S_PLAY;
               nxt    = bus.pause ? S_HOLD : S_PLAY;
            end
         end
         S_PLAY: begin
            // The cycle that sees pause still counts, keeping tone time exact.
            if (tick == TICK_LAST) begin
               tick_n = '0;
               beat_n = beat_cnt - BEAT_W'(1);
               if (beat_cnt == BEAT_W'(1)) begin
                  nxt   = S_GAP;
                  gap_n = '0;
               end
            end else begin
               tick_n = tick + TICK_CW'(1);
            end
            if (nxt == S_PLAY && bus.pause) begin
               nxt   = S_HOLD;
               ret_n = S_PLAY;
            end
         end
         S_GAP: begin
            if (gap == GAP_LAST) begin
               if (&offset) begin
                  eos = 1'b1;
               end else begin
                  offset_n = offset + SEG_W'(1);
                  nxt      = S_FETCH;
               end
            end else begin
               gap_n = gap + GAP_CW'(1);
               if (bus.pause) begin
                  nxt   = S_HOLD;
                  ret_n = S_GAP;
               end
            end
         end
         S_HOLD: begin
            if (!bus.pause) nxt = ret;
         end
         default: nxt = S_IDLE;
      endcase

      if (eos) begin
         if (bus.loop) begin
            offset_n = '0;
            nxt      = S_FETCH;
         end else begin
            done_n = 1'b1;
            nxt    = S_IDLE;
         end
      end

      if (state != S_IDLE && !bus.en) begin
         nxt    = S_IDLE;
         done_n = 1'b0;
      end

      if (nxt == S_IDLE) begin
         note_n = '0;
         beat_n = '0;
         tick_n = '0;
         gap_n  = '0;
      end
   end

   always_comb begin
      addr_n      = (nxt == S_FETCH) ? {song_n, offset_n} : addr;
      tone_en_n   = (nxt == S_PLAY) && (note_n != '0);
      tone_rstn_n = tone_en_n || (nxt == S_HOLD);
   end

   assign bus.rom_addr  = addr;
   assign bus.note_code = note;
   assign bus.tone_en   = tone_en_q;
   assign bus.tone_rstn = tone_rstn_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.state     = state;

endmodule

// File: tb/tb_bz_music_seq.sv
// Bench for bz_music_seq: per-cycle output traces predicted from the song
// contents and compared against the sequencer outputs.
module tb_bz_music_seq;

   localparam int SONG_W    = 2;
   localparam int SEG_W     = 3;
   localparam int NOTE_W    = 5;
   localparam int BEAT_W    = 4;
   localparam int TICK_DIV  = 4;
   localparam int GAP_CYC   = 2;
   localparam int PAUSE_LEN = 10;
   localparam int W         = 14;
   localparam int BIG       = 100000;

   logic clk;
   logic rstn;

   bz_music_seq_if #(.SONG_W(SONG_W), .SEG_W(SEG_W), .NOTE_W(NOTE_W), .BEAT_W(BEAT_W)) bus ();

   bz_music_seq #(
      .SONG_W(SONG_W), .SEG_W(SEG_W), .NOTE_W(NOTE_W), .BEAT_W(BEAT_W),
      .TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // note ROM: registered read
   logic [NOTE_W+BEAT_W-1:0] rom [0:31];
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   logic [W-1:0] obs_word;
   assign obs_word = {bus.busy, bus.done, bus.tone_en, bus.tone_rstn, bus.note_code, bus.rom_addr};

   logic [W-1:0] exp_q[$];
   int n_checks;
   int n_errors;
   int pause_idx;
   int abort_idx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic b, input logic d, input logic te,
                                       input logic tr, input logic [4:0] nt, input logic [4:0] ad);
      return {b, d, te, tr, nt, ad};
   endfunction

   // Reference model: expected samples from the start edge, derived from the
   // song table. pause_k = index of the PLAY clock (not a note's last) where
   // pause rises; abort_g = index of the GAP clock where en drops.
   task automatic build(input int song, input bit lp, input int pause_k,
                        input int abort_g, input int max_n);
      int off, pk, gk, b;
      bit fin, eos;
      logic [4:0] nt, ad;
      logic [8:0] w;
      exp_q.delete();
      pause_idx = -1;
      abort_idx = -1;
      off = 0; pk = 0; gk = 0; nt = '0; fin = 0;
      ad = {2'(song), 3'(0)};
      while (!fin) begin
         if (exp_q.size() >= max_n) begin
            abort_idx = exp_q.size() - 1;
            break;
         end
         ad = {2'(song), 3'(off)};
         for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 0, 0, 0, nt, ad));
         w = rom[song*8 + off];
         b = int'(w[3:0]);
         eos = 0;
         if (b == 0) begin
            eos = 1;
         end else begin
            nt = w[8:4];
            for (int c = 0; c < b*TICK_DIV; c++) begin
               exp_q.push_back(mk(1, 0, nt != 0, nt != 0, nt, ad));
               if (c != b*TICK_DIV - 1) begin
                  if (pk == pause_k) begin
                     pause_idx = exp_q.size() - 1;
                     for (int h = 0; h < PAUSE_LEN; h++) exp_q.push_back(mk(1, 0, 0, 1, nt, ad));
                  end
                  pk++;
               end
            end
            for (int g = 0; g < GAP_CYC && !fin; g++) begin
               exp_q.push_back(mk(1, 0, 0, 0, nt, ad));
               if (gk == abort_g) begin
                  abort_idx = exp_q.size() - 1;
                  fin = 1;
               end
               gk++;
            end
            if (!fin) begin
               if (off == 7) eos = 1;
               else off++;
            end
         end
         if (!fin && eos) begin
            if (lp) begin
               off = 0;
            end else begin
               exp_q.push_back(mk(0, 1, 0, 0, 0, ad));
               fin = 1;
            end
         end
      end
      if (abort_idx >= 0) exp_q.push_back(mk(0, 0, 0, 0, 0, ad));
   endtask

   // driver: start a song on the next edge
   task automatic start_song(input int song, input bit lp);
      @(negedge clk);
      bus.song_sel = 2'(song);
      bus.loop     = lp;
      bus.en       = 1'b1;
   endtask

   // driver + scoreboard: one expected sample per clock, while scrambling song_sel
   task automatic run(input bit keep_en, input int lim);
      int n;
      logic [W-1:0] e;
      n = exp_q.size();
      for (int i = 0; i < n && i < lim; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("trace[%0d]", i), 32'(obs_word), 32'(e));
         bus.song_sel = 2'($urandom_range(0, 3));
         if (i == pause_idx) bus.pause = 1'b1;
         if (pause_idx >= 0 && i == pause_idx + PAUSE_LEN) bus.pause = 1'b0;
         if (i == abort_idx) bus.en = 1'b0;
         if (i == n - 1 && !keep_en) bus.en = 1'b0;
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check(tag, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int pass_len, song, endpos, lp, pk, ag;
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 32; i++) rom[i] = '0;
      bus.en = 1'b0; bus.pause = 1'b0; bus.loop = 1'b0; bus.song_sel = '0;
      rstn = 1'b0;

      #3;
      check("reset_outputs", 32'(obs_word), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // single note then end marker
      rom[8] = {5'd5, 4'd2};
      rom[9] = {5'd0, 4'd0};
      start_song(1, 0);
      build(1, 0, -1, -1, BIG);
      run(1, BIG);
      bus.song_sel = 2'd1;
      @(negedge clk);
      check("restart_busy", 32'(bus.busy), 32'd1);
      check("restart_addr", 32'(bus.rom_addr), 32'd8);
      check("restart_done", 32'(bus.done), 32'd0);
      bus.en = 1'b0;
      @(negedge clk);
      check("abort_fetch", 32'(obs_word), 32'(mk(0, 0, 0, 0, 0, 5'd8)));
      idle_check("idle_1");

      // rest followed by a note
      rom[16] = {5'd0, 4'd1};
      rom[17] = {5'd7, 4'd1};
      rom[18] = {5'd0, 4'd0};
      start_song(2, 0);
      build(2, 0, -1, -1, BIG);
      run(0, BIG);
      idle_check("idle_2");

      // looping over a full 8-entry segment
      pass_len = 0;
      for (int i = 0; i < 8; i++) begin
         rom[24+i] = {5'(i + 1), 4'((i % 3) + 1)};
         pass_len += 3 + ((i % 3) + 1) * TICK_DIV + GAP_CYC;
      end
      start_song(3, 1);
      build(3, 1, -1, -1, pass_len + 10);
      run(0, BIG);
      idle_check("idle_3");

      // pause mid-note
      start_song(1, 0);
      build(1, 0, 2, -1, BIG);
      run(0, BIG);
      idle_check("idle_4");

      // abort in GAP
      start_song(1, 0);
      build(1, 0, -1, 0, BIG);
      run(0, BIG);
      idle_check("idle_5");

      // asynchronous reset mid-note, then restart from offset 0
      start_song(1, 0);
      build(1, 0, -1, -1, BIG);
      run(1, 6);
      #2 rstn = 1'b0;
      #1 check("rst_async", 32'(obs_word), 32'd0);
      check("rst_tone_en", 32'(bus.tone_en), 32'd0);
      @(negedge clk);
      check("rst_hold", 32'(obs_word), 32'd0);
      bus.song_sel = 2'd1;
      rstn = 1'b1;
      build(1, 0, -1, -1, BIG);
      run(0, BIG);
      idle_check("idle_6");

      // random songs with random pause / abort / loop
      for (int it = 0; it < 10; it++) begin
         song = $urandom_range(0, 3);
         for (int i = 0; i < 8; i++)
            rom[song*8+i] = {($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                             4'($urandom_range(1, 3))};
         endpos = $urandom_range(0, 8);
         if (endpos < 8) rom[song*8+endpos] = {5'($urandom_range(0, 31)), 4'd0};
         lp = $urandom_range(0, 3) == 0 ? 1 : 0;
         pk = $urandom_range(0, 1) == 0 ? -1 : $urandom_range(0, 12);
         ag = $urandom_range(0, 2) == 0 ? $urandom_range(0, 5) : -1;
         start_song(song, lp[0]);
         build(song, lp[0], pk, ag, lp[0] ? 150 : BIG);
         run(0, BIG);
         idle_check($sformatf("idle_rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bz_music_seq.md
BZ_MUSIC_SEQ -- requirements
Module: bz_music_seq

Interface
REQ-001 Parameter SONG_W, default 2, meaning song-select width; 2^SONG_W songs.
REQ-002 Parameter SEG_W, default 6, meaning per-song ROM segment address width; segment length 2^SEG_W entries.
REQ-003 Parameter NOTE_W, default 5, meaning note-code width; code 0 is a rest.
REQ-004 Parameter BEAT_W, default 4, meaning beat-length width; length 0 is the end-of-song marker.
REQ-005 Parameter TICK_DIV, default 3_125_000, meaning clocks per beat unit; legal range is >=2.
REQ-006 Parameter GAP_CYC, default 250_000, meaning silent articulation clocks after each note; legal range is >=1.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rstn  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  play request; level-sensitive; low aborts playback.
REQ-010 pause  input  1  freeze playback while high.
REQ-011 loop  input  1  restart the song at end instead of finishing; sampled at end-of-song.
REQ-012 song_sel  input  SONG_W  song index; sampled only on IDLE->FETCH.
REQ-013 rom_addr  output  SONG_W+SEG_W  synchronous note ROM address, {song, offset}.
REQ-014 rom_data  input  NOTE_W+BEAT_W  ROM word {note, beat}; valid exactly 1 clock after rom_addr.
REQ-015 note_code  output  NOTE_W  note presented to the tone PWM.
REQ-016 tone_en  output  1  tone PWM enable.
REQ-017 tone_rstn  output  1  tone PWM active-low reset; low forces phase restart.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-clock pulse on natural (non-aborted) song completion.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT, LOAD, PLAY, GAP and HOLD; all outputs SHALL be registered with no combinational input-to-output path.
REQ-021 IDLE: en=1 -> FETCH; latch song_sel; offset:=0.
REQ-022 FETCH: rom_addr = {song, offset}; -> WAIT.
REQ-023 WAIT: -> LOAD.
REQ-024 LOAD: capture rom_data; beat=0 -> end-of-song; else -> PLAY with beat counter := beat and tick counter := 0.
REQ-025 PLAY: tick counts 0..TICK_DIV-1; at wrap, beat counter decrements; when it reaches 0 -> GAP; PLAY duration SHALL be exactly beat*TICK_DIV clocks.
REQ-026 PLAY outputs: note_code = captured note; tone_en=1 and tone_rstn=1 when note!=0; tone_en=0 and tone_rstn=0 for a rest.
REQ-027 GAP: tone_en=0, tone_rstn=0 for exactly GAP_CYC clocks; then offset+1 -> FETCH.
REQ-028 Offset wrap: when GAP completes at offset 2^SEG_W-1, treat as end-of-song; offset never carries into song bits.
REQ-029 End-of-song: loop=1 -> offset:=0 and -> FETCH with the same latched song; loop=0 -> done=1 for one clock and -> IDLE.
REQ-030 pause=1 in PLAY or GAP -> HOLD; tick, beat and gap counters frozen; tone_en=0 and tone_rstn=1 (phase retained).
REQ-031 HOLD with pause=0 SHALL return to the state it left, resuming counts where frozen.
REQ-032 pause in FETCH/WAIT/LOAD SHALL take effect at the next PLAY entry, with no ROM access lost.
REQ-033 en=0 in any non-IDLE state -> IDLE next clock; no done pulse; tone_en and tone_rstn low.
REQ-034 Simultaneous events: priority SHALL be en=0, then end-of-song, then pause.
REQ-035 Latency from en sampled high in IDLE to tone_en=1 SHALL be 4 clocks for a non-rest first note.
REQ-036 Changes on song_sel while busy SHALL be ignored until the next start.
REQ-037 After done or an abort, a start with en held high SHALL re-enter FETCH on the next clock.

Reset
REQ-038 rstn low SHALL asynchronously force IDLE and set rom_addr=0, note_code=0, tone_en=0, tone_rstn=0, busy=0, done=0, and all counters to 0.
REQ-039 rstn asserted mid-note SHALL silence tone_en immediately, with no done pulse; playback restarts only via en after release.

Verification (TICK_DIV=4, GAP_CYC=2, SEG_W=3)
REQ-040 Song 1 = {note 5, beat 2},{0,0}; en=1 -> rom_addr=8, tone_en=1 for 8 clocks, note_code=5, gap of 2 clocks, done pulse once, then IDLE.
REQ-041 Entry {note 0, beat 1} -> 4 clocks with tone_en=0 and tone_rstn=0, then the next address is fetched.
REQ-042 loop=1 with 8 non-zero entries -> rom_addr sequence 0..7 then 0 again, no done pulse, song bits unchanged.
REQ-043 pause high for 10 clocks mid-PLAY -> tone_en=0 and tone_rstn=1 for the pause; total PLAY clocks still equal beat*4.
REQ-044 en dropped during GAP -> IDLE next clock, busy=0, no done pulse; song_sel changed while busy has no effect.
REQ-045 rstn pulsed low during PLAY -> all outputs 0 asynchronously; after release with en=1, playback restarts from offset 0.
